// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong dimensions, collision FSM states and saturating velocity helpers
package pong_pkg;

  localparam int DEF_SCREEN_WIDTH     = 640;
  localparam int DEF_SCREEN_HEIGHT    = 480;
  localparam int DEF_PADDLE_WIDTH     = 20;
  localparam int DEF_PADDLE_HEIGHT    = 80;
  localparam int DEF_BALL_SIZE        = 10;
  localparam int DEF_NUM_ZONES        = 5;
  localparam int DEF_DEFLECT_STEP     = 1;
  localparam int DEF_VMAX             = 8;
  localparam int DEF_HITS_PER_SPEEDUP = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WALL,
    ST_PADDLE,
    ST_SPEED,
    ST_DONE
  } state_t;

  // Signed 16-bit add clamped to the representable range.
  function automatic logic signed [15:0] sat_add16(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic signed [16:0] sum;
    sum = $signed({a[15], a}) + $signed({b[15], b});
    if (sum > 17'sd32767) return 16'sh7fff;
    if (sum < -17'sd32768) return 16'sh8000;
    return sum[15:0];
  endfunction

  // Negation that maps -32768 to +32767 instead of wrapping back to itself.
  function automatic logic signed [15:0] sat_neg16(input logic signed [15:0] a);
    return (a == 16'sh8000) ? 16'sh7fff : -a;
  endfunction

endpackage

// File: rtl/paddle_zone_deflect.sv
// rtl/paddle_zone_deflect.sv - maps a paddle-relative hit offset to a deflected, VMAX-limited vy
module paddle_zone_deflect
  import pong_pkg::*;
#(
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int NUM_ZONES     = DEF_NUM_ZONES,
  parameter int DEFLECT_STEP  = DEF_DEFLECT_STEP,
  parameter int VMAX          = DEF_VMAX
) (
  input  logic signed [17:0] offset,
  input  logic signed [15:0] vy,
  output logic signed [15:0] vy_deflected
);

  localparam logic signed [15:0] VMAX_POS = 16'(VMAX);
  localparam logic signed [15:0] VMAX_NEG = 16'(-VMAX);

  int                 offset_clamped;
  int                 zone;
  logic signed [15:0] delta;
  logic signed [15:0] summed;

  // Clamp the offset onto the paddle, count zone thresholds at or below it, then deflect and limit vy.
  always_comb begin
    offset_clamped = int'(offset);
    if (offset_clamped < 0) begin
      offset_clamped = 0;
    end else if (offset_clamped > PADDLE_HEIGHT - 1) begin
      offset_clamped = PADDLE_HEIGHT - 1;
    end
    zone = 0;
    for (int k = 1; k < NUM_ZONES; k++) begin
      if ((k * PADDLE_HEIGHT) / NUM_ZONES <= offset_clamped) zone = zone + 1;
    end
    delta  = 16'((zone - (NUM_ZONES - 1) / 2) * DEFLECT_STEP);
    summed = sat_add16(vy, delta);
    if (summed > VMAX_POS) begin
      vy_deflected = VMAX_POS;
    end else if (summed < VMAX_NEG) begin
      vy_deflected = VMAX_NEG;
    end else begin
      vy_deflected = summed;
    end
  end

endmodule

// File: rtl/paddle_collision_engine.sv
// rtl/paddle_collision_engine.sv - per-frame wall/paddle/miss resolver; PONG_SPEEDUP_EN adds hit-driven vx speed-up
module paddle_collision_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_WIDTH     = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT    = DEF_SCREEN_HEIGHT,
  parameter int PADDLE_WIDTH     = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT    = DEF_PADDLE_HEIGHT,
  parameter int BALL_SIZE        = DEF_BALL_SIZE,
  parameter int NUM_ZONES        = DEF_NUM_ZONES,
  parameter int DEFLECT_STEP     = DEF_DEFLECT_STEP,
  parameter int VMAX             = DEF_VMAX,
  parameter int HITS_PER_SPEEDUP = DEF_HITS_PER_SPEEDUP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [15:0] ball_x,
  input  logic [15:0] ball_y,
  input  logic [15:0] ball_vx,
  input  logic [15:0] ball_vy,
  input  logic [15:0] paddle1_y,
  input  logic [15:0] paddle2_y,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] vx_out,
  output logic [15:0] vy_out,
  output logic        hit_p1,
  output logic        hit_p2,
  output logic        wall_hit,
  output logic        score_p1,
  output logic        score_p2,
  output logic [7:0]  rally_count
);

  localparam logic [16:0] BOTTOM_LIMIT = 17'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic [16:0] P1_LIMIT     = 17'(PADDLE_WIDTH);
  localparam logic [16:0] P2_LIMIT     = 17'(SCREEN_WIDTH - PADDLE_WIDTH);
  localparam logic [16:0] RIGHT_LIMIT  = 17'(SCREEN_WIDTH - BALL_SIZE);

  state_t             state, state_next;
  logic [15:0]        bx, by, p1y, p2y;
  logic signed [15:0] vx, vy, vx_final, vy_deflected;
  logic               wall_r, hit1_r, hit2_r, score1_r, score2_r;
  logic [15:0]        paddle_y;
  logic [16:0]        ball_bottom, ball_right, paddle_bottom;
  logic signed [17:0] hit_offset;
  logic               y_overlap, in_p1, in_p2, paddle_hit, miss_left, miss_right;

  // Only the paddle the ball is heading toward can be hit, so one overlap/zone path serves both.
  assign paddle_y      = vx[15] ? p1y : p2y;
  assign ball_bottom   = {1'b0, by} + 17'(BALL_SIZE);
  assign ball_right    = {1'b0, bx} + 17'(BALL_SIZE);
  assign paddle_bottom = {1'b0, paddle_y} + 17'(PADDLE_HEIGHT);
  assign y_overlap     = (ball_bottom > {1'b0, paddle_y}) && ({1'b0, by} < paddle_bottom);
  assign in_p1         = ({1'b0, bx} <= P1_LIMIT) && (vx < 16'sd0) && y_overlap;
  assign in_p2         = (ball_right >= P2_LIMIT) && (vx > 16'sd0) && y_overlap;
  assign paddle_hit    = in_p1 | in_p2;
  assign miss_left     = (bx == 16'd0);
  assign miss_right    = ({1'b0, bx} >= RIGHT_LIMIT);
  assign hit_offset    = $signed({2'b00, by}) - $signed({2'b00, paddle_y})
                       + $signed(18'(BALL_SIZE / 2));

  paddle_zone_deflect #(
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .NUM_ZONES    (NUM_ZONES),
    .DEFLECT_STEP (DEFLECT_STEP),
    .VMAX         (VMAX)
  ) u_zone (
    .offset      (hit_offset),
    .vy          (vy),
    .vy_deflected(vy_deflected)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Fixed walk through the resolve stages; a tick is only accepted from IDLE.
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE:    if (frame_tick) state_next = ST_CAPTURE;
      ST_CAPTURE: begin busy = 1'b1; state_next = ST_WALL;   end
      ST_WALL:    begin busy = 1'b1; state_next = ST_PADDLE; end
      ST_PADDLE:  begin busy = 1'b1; state_next = ST_SPEED;  end
      ST_SPEED:   begin busy = 1'b1; state_next = ST_DONE;   end
      ST_DONE:    begin busy = 1'b1; result_valid = 1'b1; state_next = ST_IDLE; end
      default:    state_next = ST_IDLE;
    endcase
  end

`ifdef PONG_SPEEDUP_EN
  logic [7:0] hit_count, hit_count_next;
  int         vx_mag;

  // Every HITS_PER_SPEEDUP-th paddle hit grows |vx| by one, never past VMAX.
  always_comb begin
    hit_count_next = hit_count;
    vx_final       = vx;
    vx_mag         = vx[15] ? -int'(vx) : int'(vx);
    if (hit1_r || hit2_r) begin
      if (int'(hit_count) + 1 >= HITS_PER_SPEEDUP) begin
        hit_count_next = 8'd0;
        if (vx_mag < VMAX) vx_final = vx[15] ? vx - 16'sd1 : vx + 16'sd1;
      end else begin
        hit_count_next = hit_count + 8'd1;
      end
    end
  end

  // A miss restarts the speed-up count; SPEED commits the updated count.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count <= 8'd0;
    end else if (state == ST_PADDLE && !paddle_hit && (miss_left || miss_right)) begin
      hit_count <= 8'd0;
    end else if (state == ST_SPEED) begin
      hit_count <= hit_count_next;
    end
  end
`else
  // HITS_PER_SPEEDUP has no effect in this build; SPEED forwards vx untouched.
  logic [31:0] unused_hits_per_speedup;
  assign unused_hits_per_speedup = 32'(HITS_PER_SPEEDUP);
  assign vx_final = vx;
`endif

  // Capture on an accepted tick, then resolve wall, paddle/miss and speed stages in turn.
  always_ff @(posedge clk) begin
    if (reset) begin
      bx          <= 16'd0;
      by          <= 16'd0;
      p1y         <= 16'd0;
      p2y         <= 16'd0;
      vx          <= 16'sd0;
      vy          <= 16'sd0;
      wall_r      <= 1'b0;
      hit1_r      <= 1'b0;
      hit2_r      <= 1'b0;
      score1_r    <= 1'b0;
      score2_r    <= 1'b0;
      rally_count <= 8'd0;
      vx_out      <= 16'd0;
      vy_out      <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            bx       <= ball_x;
            by       <= ball_y;
            vx       <= $signed(ball_vx);
            vy       <= $signed(ball_vy);
            p1y      <= paddle1_y;
            p2y      <= paddle2_y;
            wall_r   <= 1'b0;
            hit1_r   <= 1'b0;
            hit2_r   <= 1'b0;
            score1_r <= 1'b0;
            score2_r <= 1'b0;
          end
        end
        ST_WALL: begin
          if (by == 16'd0 && vy < 16'sd0) begin
            vy     <= sat_neg16(vy);
            wall_r <= 1'b1;
          end else if ({1'b0, by} >= BOTTOM_LIMIT && vy > 16'sd0) begin
            vy     <= sat_neg16(vy);
            wall_r <= 1'b1;
          end
        end
        ST_PADDLE: begin
          if (paddle_hit) begin
            vx     <= sat_neg16(vx);
            vy     <= vy_deflected;
            hit1_r <= in_p1;
            hit2_r <= in_p2;
            if (rally_count != 8'hff) rally_count <= rally_count + 8'd1;
          end else if (miss_left) begin
            score2_r    <= 1'b1;
            rally_count <= 8'd0;
          end else if (miss_right) begin
            score1_r    <= 1'b1;
            rally_count <= 8'd0;
          end
        end
        ST_SPEED: begin
          vx_out <= vx_final;
          vy_out <= vy;
        end
        default: ;
      endcase
    end
  end

  // Event flags are only visible in the result cycle.
  assign hit_p1   = result_valid & hit1_r;
  assign hit_p2   = result_valid & hit2_r;
  assign wall_hit = result_valid & wall_r;
  assign score_p1 = result_valid & score1_r;
  assign score_p2 = result_valid & score2_r;

endmodule
